// File: rtl/shift_iter_pkg.sv
// Shared types for the iterative shifter.
// Op and FSM encodings plus default geometry.
package shift_iter_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_SRA = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Index width for a counter that walks 0..n-1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_iter_step.sv
// One power-of-two shift stage, purely combinational.
// amt is one-hot, so it doubles as the shift distance.
module shift_step
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic [WIDTH-1:0] In,
  input  op_e              Op,
  input  logic [CNT_W-1:0] amt,
  output logic [WIDTH-1:0] Out
);

  localparam logic [CNT_W:0] W_L = (CNT_W + 1)'(WIDTH);

  logic [CNT_W:0] rsh;

  assign rsh = W_L - {1'b0, amt};

  // Select the stage result for the requested op.
  always_comb begin
    Out = In;
    unique case (Op)
      OP_ROL: Out = (In << amt) | (In >> rsh);
      OP_SLL: Out = In << amt;
      OP_SRA: Out = $unsigned($signed(In) >>> amt);
      OP_SRL: Out = In >> amt;
      default: Out = In;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle shifter: one binary stage per cycle.
// Fixed CNT_W-cycle latency, result held until taken.
module shift_iter
  import shift_iter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [1:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             busy
);

  localparam int K_W = idx_w(CNT_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(CNT_W - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ov_q, ov_d;

  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] nxt;

  assign amt = ONE << k_q;

  shift_step #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_step (
    .In (work_q),
    .Op (op_q),
    .amt(amt),
    .Out(step)
  );

  // Apply the stage only when this count bit is set.
  assign nxt = cnt_q[k_q] ? step : work_q;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_ROL;
      work_q  <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      work_q  <= work_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Next state and datapath updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    work_d  = work_q;
    out_d   = out_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = In;
          cnt_d   = Cnt;
          op_d    = op_e'(Op);
          k_d     = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = nxt;
        k_d    = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          out_d   = nxt;
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ov_d    = 1'b0;
        k_d     = '0;
      end
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = ov_q;
    Out       = out_q;
  end

endmodule
